// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the fetch sequencer: the FSM state encoding (3 bits),
// the PC width, the instruction width and the watchdog limit.
// The watchdog constants are used only when FETCH_SEQ_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

   localparam int PC_W    = 5;
   localparam int INSTR_W = 9;
   localparam int WDOG_W  = 4;

   localparam logic [WDOG_W-1:0] WDOG_LIMIT = 4'd15;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WAIT  = 3'd2,
      LATCH = 3'd3,
      ISSUE = 3'd4,
      EXEC  = 3'd5,
      ERROR = 3'd6
   } state_t;

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pc_counter
// Program counter register: synchronous clear (has priority), increment
// enable, wraps modulo 2**PC_W.
// Ports:
//   clock  in   system clock
//   clear  in   synchronous clear to 0
//   inc    in   increment enable
//   pc     out  current program counter
// -----------------------------------------------------------------------------
module fetch_sequencer_pc_counter
   import fetch_sequencer_pkg::*;
(
   input  logic            clock,
   input  logic            clear,
   input  logic            inc,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clock) begin
      if (clear) begin
         pc <= '0;
      end else if (inc) begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Fetches instruction words from a synchronous ROM (1-cycle read latency),
// latches each word, issues it to the processor with a one-cycle run pulse
// and waits for the processor's done strobe before fetching the next word.
// Execution stops after last_addr (PC wraps to 0) or after a halt request.
//
// Optional feature: define FETCH_SEQ_WATCHDOG_EN to add a 4-bit watchdog
// that moves the FSM to ERROR when EXEC lasts 15 cycles without done.
//
// Handshake: run is a single-cycle issue pulse; the instruction on instr is
// stable from that cycle until the next LATCH. done is only honoured in EXEC.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   start      in   level, begins execution from current PC when in IDLE
//   halt       in   level, stop after the in-flight instruction retires
//   last_addr  in   address of the final program word
//   mem_data   in   ROM read data
//   done       in   processor instruction-complete strobe
//   mem_addr   out  ROM read address (= PC)
//   instr      out  latched instruction
//   run        out  one-cycle issue pulse
//   busy       out  high in every state except IDLE and ERROR
//   error      out  high in ERROR
//   retired    out  retired instruction count (wraps)
//   state_dbg  out  current FSM state
// -----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_sequencer_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               halt,
   input  logic [PC_W-1:0]    last_addr,
   input  logic [INSTR_W-1:0] mem_data,
   input  logic               done,
   output logic [PC_W-1:0]    mem_addr,
   output logic [INSTR_W-1:0] instr,
   output logic               run,
   output logic               busy,
   output logic               error,
   output logic [7:0]         retired,
   output logic [2:0]         state_dbg
);

   state_t          state;
   logic [PC_W-1:0] pc;
   logic            retire;
   logic            pc_clear;
   logic            pc_inc;

   // Retirement happens only in EXEC; reset overrides everything.
   assign retire   = (state == EXEC) && done && !reset;
   assign pc_clear = reset || (retire && (pc == last_addr));
   assign pc_inc   = retire && (pc != last_addr);

   fetch_sequencer_pc_counter pc_counter (
      .clock (clock),
      .clear (pc_clear),
      .inc   (pc_inc),
      .pc    (pc)
   );

   assign mem_addr  = pc;
   assign state_dbg = state;

`ifdef FETCH_SEQ_WATCHDOG_EN
   logic [WDOG_W-1:0] wdog;
`else
   assign error = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         instr   <= '0;
         run     <= 1'b0;
         busy    <= 1'b0;
         retired <= '0;
`ifdef FETCH_SEQ_WATCHDOG_EN
         error   <= 1'b0;
         wdog    <= '0;
`endif
      end else begin
         run <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !halt) begin
                  state <= ADDR;
                  busy  <= 1'b1;
               end
            end
            ADDR:  state <= WAIT;
            WAIT:  state <= LATCH;
            LATCH: begin
               instr <= mem_data;
               state <= ISSUE;
               run   <= 1'b1;   // registered so it is high exactly in ISSUE
            end
            ISSUE: begin
               state <= EXEC;
`ifdef FETCH_SEQ_WATCHDOG_EN
               wdog  <= '0;
`endif
            end
            EXEC: begin
               if (done) begin
                  retired <= retired + 8'd1;
                  // Wrap at last_addr wins over halt; both return to IDLE.
                  if ((pc == last_addr) || halt) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= ADDR;
                  end
               end
`ifdef FETCH_SEQ_WATCHDOG_EN
               // The 15th EXEC cycle without done moves to ERROR.
               else if (wdog == WDOG_LIMIT - 4'd1) begin
                  state <= ERROR;
                  busy  <= 1'b0;
                  error <= 1'b1;
                  wdog  <= WDOG_LIMIT;
               end else begin
                  wdog <= wdog + 4'd1;
               end
`endif
            end
            ERROR: state <= ERROR;   // only reset leaves ERROR
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. A synchronous ROM model feeds the DUT,
// a responder returns done one cycle after each run pulse, and a monitor
// pops the expected {gap, addr, instr} entry on every run pulse.
// Define FETCH_SEQ_WATCHDOG_EN for both bench and RTL to exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic       start     = 1'b0;
   logic       halt      = 1'b0;
   logic [4:0] last_addr = 5'd0;
   logic [8:0] mem_data;
   logic       done;
   logic       done_auto = 1'b0;
   logic       done_man  = 1'b0;
   logic       auto_en   = 1'b1;

   logic [4:0] mem_addr;
   logic [8:0] instr;
   logic       run;
   logic       busy;
   logic       error;
   logic [7:0] retired;
   logic [2:0] state_dbg;

   logic [8:0] rom [32];
   logic [8:0] rom_q = 9'd0;

   int n_tests  = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_run = 0;

   // Entry: {expected gap in cycles (0 = unchecked), addr, instr}
   logic [21:0] exp_q[$];
   logic [21:0] mon_e;

   fetch_sequencer dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .halt      (halt),
      .last_addr (last_addr),
      .mem_data  (mem_data),
      .done      (done),
      .mem_addr  (mem_addr),
      .instr     (instr),
      .run       (run),
      .busy      (busy),
      .error     (error),
      .retired   (retired),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / ROM ----------------
   always #5 clock = ~clock;

   always @(posedge clock) rom_q <= rom[mem_addr];
   assign mem_data = rom_q;
   assign done     = done_auto | done_man;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int a, input int gap);
      logic [4:0] ad;
      logic [7:0] g;
      ad = a[4:0];
      g  = gap[7:0];
      exp_q.push_back({g, ad, rom[ad]});
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int k;
      k = 0;
      while (state_dbg !== s && k < budget) begin
         tick();
         k++;
      end
      check(name, state_dbg, s);
   endtask

   task automatic wait_at(input logic [2:0] s, input logic [4:0] a, input int budget,
                          input string name);
      int k;
      k = 0;
      while (!(state_dbg === s && mem_addr === a) && k < budget) begin
         tick();
         k++;
      end
      check(name, {state_dbg, mem_addr}, {s, a});
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // ---------------- done responder ----------------
   always begin
      @(negedge clock);
      if (auto_en && run) begin
         @(posedge clock);
         #1 done_auto = 1'b1;
         @(posedge clock);
         #1 done_auto = 1'b0;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      cyc++;
      if (run === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_run", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("issue_addr", mem_addr, mon_e[13:9]);
            check("issue_instr", instr, mon_e[8:0]);
            if (mon_e[21:14] != 8'd0) check("issue_gap", cyc - last_run, mon_e[21:14]);
         end
         last_run = cyc;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 9'((i * 37 + 5) % 512);
      rom[0] = 9'b001000000;
      rom[1] = 9'b000001000;

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      check("rst_state",   state_dbg, IDLE);
      check("rst_addr",    mem_addr, 5'd0);
      check("rst_instr",   instr, 9'd0);
      check("rst_run",     run, 1'b0);
      check("rst_busy",    busy, 1'b0);
      check("rst_error",   error, 1'b0);
      check("rst_retired", retired, 8'd0);
      reset = 1'b0;

      // Two-word program, run pulses 5 cycles apart
      last_addr = 5'd1;
      push(0, 0);
      push(1, 5);
      start_pulse();
      check("busy_running", busy, 1'b1);
      wait_state(IDLE, 40, "prog2_idle");
      check("prog2_retired", retired, 8'd2);
      check("prog2_pc",      mem_addr, 5'd0);
      check("prog2_busy",    busy, 1'b0);
      check("prog2_instr",   instr, 9'b000001000);

      // Done outside EXEC is ignored (IDLE, then ADDR)
      done_man = 1'b1;
      tick();
      done_man = 1'b0;
      check("idle_done_ret", retired, 8'd2);
      check("idle_done_pc",  mem_addr, 5'd0);
      push(0, 0);
      push(1, 5);
      start_pulse();
      done_man = 1'b1;
      tick();
      done_man = 1'b0;
      check("addr_done_state", state_dbg, WAIT);
      check("addr_done_ret",   retired, 8'd2);
      check("addr_done_pc",    mem_addr, 5'd0);
      wait_state(IDLE, 40, "rerun_idle");
      check("rerun_retired", retired, 8'd4);

      // Halt raised during WAIT of word 2
      last_addr = 5'd5;
      push(0, 0);
      push(1, 5);
      push(2, 5);
      start_pulse();
      wait_at(WAIT, 5'd2, 40, "reach_wait2");
      halt = 1'b1;
      wait_state(IDLE, 40, "halt_idle");
      check("halt_pc",      mem_addr, 5'd3);
      check("halt_retired", retired, 8'd7);
      check("halt_busy",    busy, 1'b0);
      halt = 1'b0;
      push(3, 0);
      push(4, 5);
      push(5, 5);
      start_pulse();
      check("resume_state", state_dbg, ADDR);
      check("resume_addr",  mem_addr, 5'd3);
      wait_state(IDLE, 40, "resume_idle");
      check("resume_retired", retired, 8'd10);
      check("resume_pc",      mem_addr, 5'd0);

      // Run to PC=30 via halt, then words 30, 31 and wrap
      last_addr = 5'd31;
      push(0, 0);
      for (int i = 1; i < 30; i++) push(i, 5);
      start_pulse();
      wait_at(ISSUE, 5'd29, 400, "reach_issue29");
      halt = 1'b1;
      wait_state(IDLE, 20, "pc30_idle");
      check("pc30_pc",      mem_addr, 5'd30);
      check("pc30_retired", retired, 8'd40);
      halt = 1'b0;
      push(30, 0);
      push(31, 5);
      start_pulse();
      wait_state(IDLE, 40, "wrap_idle");
      check("wrap_pc",      mem_addr, 5'd0);
      check("wrap_retired", retired, 8'd42);

      // Reset in EXEC with done high
      auto_en = 1'b0;
      push(0, 0);
      start_pulse();
      wait_state(EXEC, 20, "reach_exec_rst");
      done_man = 1'b1;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
      done_man = 1'b0;
      check("mid_rst_state",   state_dbg, IDLE);
      check("mid_rst_addr",    mem_addr, 5'd0);
      check("mid_rst_instr",   instr, 9'd0);
      check("mid_rst_run",     run, 1'b0);
      check("mid_rst_busy",    busy, 1'b0);
      check("mid_rst_error",   error, 1'b0);
      check("mid_rst_retired", retired, 8'd0);

      // Done never arrives
      push(0, 0);
      start_pulse();
      wait_state(EXEC, 20, "reach_exec_wd");
`ifdef FETCH_SEQ_WATCHDOG_EN
      repeat (14) tick();
      check("wd_pre_error", error, 1'b0);
      check("wd_pre_state", state_dbg, EXEC);
      tick();
      check("wd_error", error, 1'b1);
      check("wd_busy",  busy, 1'b0);
      check("wd_state", state_dbg, ERROR);
      tick();
      check("wd_hold_state", state_dbg, ERROR);
      check("wd_hold_pc",    mem_addr, 5'd0);
      check("wd_hold_instr", instr, 9'b001000000);
`else
      repeat (20) tick();
      check("nowd_busy",  busy, 1'b1);
      check("nowd_error", error, 1'b0);
      check("nowd_state", state_dbg, EXEC);
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("final_rst_state", state_dbg, IDLE);
      check("final_rst_error", error, 1'b0);
      auto_en = 1'b1;

      tick();
      check("queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Clock  in  1  single system clock; all state updates on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 Start  in  1  level; sampled in IDLE, begins program execution from current PC.
REQ-004 Halt  in  1  level; requests stop after the in-flight instruction retires.
REQ-005 LastAddr  in  5  address of final program word.
REQ-006 MemData  in  9  instruction word from synchronous instruction ROM (1-cycle read latency).
REQ-007 Done  in  1  processor instruction-complete strobe.
REQ-008 MemAddr  out  5  ROM read address (= PC).
REQ-009 Instr  out  9  latched instruction presented to processor control unit.
REQ-010 Run  out  1  one-cycle issue pulse to processor.
REQ-011 Busy  out  1  high in every state except IDLE and ERROR.
REQ-012 Error  out  1  high in ERROR state.
REQ-013 Retired  out  8  count of retired instructions, wraps 255->0.

Function
REQ-014 FSM states SHALL be IDLE, ADDR, WAIT, LATCH, ISSUE, EXEC, ERROR.
REQ-015 IDLE: Start=1 and Halt=0 -> ADDR; otherwise remain.
REQ-016 ADDR: MemAddr driven with PC -> WAIT (ROM read launched).
REQ-017 WAIT -> LATCH unconditionally (covers ROM latency).
REQ-018 LATCH: Instr <= MemData -> ISSUE; Instr SHALL hold its value in all other states.
REQ-019 ISSUE: Run=1 for exactly this cycle -> EXEC; Run=0 in every other state.
REQ-020 EXEC: on Done=1, Retired increments, then: PC==LastAddr -> PC<=0, IDLE; else Halt=1 -> PC<=PC+1, IDLE; else PC<=PC+1, ADDR.
REQ-021 Issue-to-issue minimum latency SHALL be 5 cycles (ISSUE, EXEC w/ Done, ADDR, WAIT, LATCH).
REQ-022 PC SHALL be 5 bits, increment modulo 32; LastAddr=31 wraps PC to 0 and stops.
REQ-023 Done asserted outside EXEC SHALL be ignored (no count, no PC change).
REQ-024 Halt asserted in ADDR/WAIT/LATCH/ISSUE SHALL NOT abort; instruction still issues, stop evaluated at Done.
REQ-025 Done and Halt simultaneously in EXEC: instruction retires, PC advances, FSM -> IDLE.
REQ-026 Start held high in IDLE after a stop SHALL restart on the next cycle from current PC.

Reset
REQ-027 Reset=1 SHALL force next edge: state IDLE, PC=0, MemAddr=0, Instr=0, Run=0, Busy=0, Error=0, Retired=0, watchdog=0.
REQ-028 Reset mid-instruction (any state, including EXEC with Done=1) SHALL take priority; no retire counted.
REQ-029 Reset is the only exit from ERROR.

Configuration
REQ-030 Macro FETCH_SEQ_WATCHDOG_EN: when defined, 4-bit watchdog clears on ISSUE, counts each EXEC cycle without Done; reaching 15 -> ERROR (Error=1, Busy=0, PC/Instr held).
REQ-031 Without FETCH_SEQ_WATCHDOG_EN: no watchdog logic, EXEC waits indefinitely, ERROR unreachable, Error tied 0.

Structure
REQ-032 Shared package SHALL hold state encoding (3-bit), PC width (5), instruction width (9), watchdog limit (15).
REQ-033 Sub-module pc_counter SHALL implement PC register with synchronous clear, increment-enable, modulo-32 wrap.

Verification
REQ-034 ROM [0]=001000000 (mvi R0), [1]=000001000, LastAddr=1, Start pulse, Done 1 cycle after each Run -> two Run pulses 5 cycles apart, Instr=001000000 then 000001000, Retired=2, PC=0, IDLE.
REQ-035 LastAddr=5, Halt raised during WAIT of word 2 -> word 2 still issues, after its Done PC=3, IDLE, Retired=3; Start -> resumes fetching address 3.
REQ-036 Done pulsed in IDLE and ADDR -> Retired and PC unchanged.
REQ-037 Reset asserted in EXEC with Done=1 -> next cycle all outputs zero, Retired=0.
REQ-038 With FETCH_SEQ_WATCHDOG_EN, Done never asserted -> Error=1 exactly 15 cycles after EXEC entry, Busy=0; Reset clears; without macro Busy stays 1, Error 0.
REQ-039 LastAddr=31, PC preset by running to 30 -> word 31 issues, PC wraps to 0, IDLE.
